// File: rtl/seq_detector_param_if.sv
// Signal bundle for seq_detector_param: the qualified serial input, the runtime
// configuration and the match outputs. The master drives the inputs; the detector is the slave.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  match, match_q, match_count
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output match, match_q, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Mealy detector for a runtime-programmable serial pattern of 1..MAX_LEN bits.
// It supports overlapping and non-overlapping matching and keeps a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detector_param_if.slave bus
);
    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int NUM_LANES = 1 << LEN_W;

    localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(3'b101);
    localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(3);
    localparam logic [LEN_W-1:0]   MAX_LEN_W = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic               ovl_reg, ovl_next;
    // Only the newest MAX_LEN-1 bits can ever join the incoming bit in a comparison.
    logic [MAX_LEN-2:0] hist_reg, hist_next;
    logic [LEN_W-1:0]   fill_reg, fill_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               match_q_reg;

    logic [MAX_LEN-1:0]   window;
    logic [NUM_LANES-1:0] lane_eq;
    logic [LEN_W-1:0]     len_clamped;
    logic                 armed;
    logic                 match;

    assign window = {hist_reg, bus.in_bit};

    // One comparator per possible length; unused lane indices read as no-match.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            if (gi >= 1 && gi <= MAX_LEN) begin : g_cmp
                assign lane_eq[gi] = (window[gi-1:0] == pat_reg[gi-1:0]);
            end else begin : g_none
                assign lane_eq[gi] = 1'b0;
            end
        end
    endgenerate

    assign armed       = (fill_reg >= (len_reg - LEN_W'(1)));
    assign len_clamped = (bus.cfg_len > MAX_LEN_W) ? MAX_LEN_W : bus.cfg_len;

    assign match = rst_n & bus.in_valid & ~bus.cfg_load & (len_reg != '0)
                 & armed & lane_eq[len_reg];

    always_comb begin
        pat_next   = pat_reg;
        len_next   = len_reg;
        ovl_next   = ovl_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        count_next = count_reg;

        if (bus.cfg_load) begin
            pat_next   = bus.cfg_pattern;
            len_next   = len_clamped;
            ovl_next   = bus.cfg_overlap;
            hist_next  = '0;
            fill_next  = '0;
            count_next = '0;
        end else if (bus.in_valid) begin
            hist_next = window[MAX_LEN-2:0];
            // In non-overlap mode the matched bits are consumed and cannot seed the next match.
            if (match && !ovl_reg) begin
                fill_next = '0;
            end else if (fill_reg != MAX_LEN_W) begin
                fill_next = fill_reg + LEN_W'(1);
            end
            if (match && (count_reg != '1)) begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg     <= RST_PAT;
            len_reg     <= RST_LEN;
            ovl_reg     <= 1'b1;
            hist_reg    <= '0;
            fill_reg    <= '0;
            count_reg   <= '0;
            match_q_reg <= 1'b0;
        end else begin
            pat_reg     <= pat_next;
            len_reg     <= len_next;
            ovl_reg     <= ovl_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            count_reg   <= count_next;
            match_q_reg <= match;
        end
    end

    assign bus.match       = match;
    assign bus.match_q     = match_q_reg;
    assign bus.match_count = count_reg;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios and randomized streams checked against
// a queue-based model of "last len accepted bits equal the pattern".
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [MAX_LEN-1:0] pat;
        int                 len;
        bit                 ovl;
        logic [15:0]        stream;
        int                 n;
        int                 mask;
        int                 cnt;
    } scen_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();
    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(2))     bus2 ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Reference model: accepted bits since the last restart point, oldest first.
    int                 hist_q[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    int                 m_cnt;

    task automatic model_reset();
        m_pat = MAX_LEN'(3'b101);
        m_len = 3;
        m_ovl = 1'b1;
        m_cnt = 0;
        hist_q.delete();
    endtask

    function automatic bit model_match(bit v, bit b);
        int w[$];
        if (!v || m_len == 0) return 1'b0;
        w = hist_q;
        w.push_back(int'(b));
        if (w.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (w[w.size() - m_len + i] != int'(m_pat[m_len-1-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock of stimulus: returns the observed and modelled Mealy match, then advances the model.
    task automatic drive_bit(input bit v, input bit b, output bit got, output bit exp);
        @(negedge clk);
        bus.cfg_load = 1'b0;
        bus.in_valid = v;
        bus.in_bit   = b;
        #1;
        got = bus.match;
        exp = model_match(v, b);
        @(posedge clk);
        #1;
        if (exp && m_cnt < CNT_MAX) m_cnt++;
        if (v) begin
            if (exp && !m_ovl) begin
                hist_q.delete();
            end else begin
                hist_q.push_back(int'(b));
                if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
            end
        end
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, output bit got);
        @(negedge clk);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = LEN_W'(l);
        bus.cfg_overlap = o;
        bus.in_valid    = 1'b1;
        bus.in_bit      = 1'($urandom);
        #1;
        got = bus.match;
        @(posedge clk);
        #1;
        m_pat = p;
        m_len = (l > MAX_LEN) ? MAX_LEN : l;
        m_ovl = o;
        m_cnt = 0;
        hist_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.match !== 1'b0) begin n_bad++; $display("FAIL reset_match: got %b want 0", bus.match); end
        n_cmp++; if (bus.match_q !== 1'b0) begin n_bad++; $display("FAIL reset_match_q: got %b want 0", bus.match_q); end
        n_cmp++; if (bus.match_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.match_count); end
        n_cmp++; if (bus2.match_count !== '0) begin n_bad++; $display("FAIL reset_count2: got %0d want 0", bus2.match_count); end
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_default();
        bit got, exp, want;
        bit bits[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b1, bits[i], got, exp);
            want = (i == 2 || i == 4);
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL default_match bit%0d: got %b want %b", i + 1, got, want); end
            n_cmp++; if (bus.match_q !== want) begin n_bad++; $display("FAIL default_match_q bit%0d: got %b want %b", i + 1, bus.match_q, want); end
            $display("default: bit%0d=%b match=%b match_q=%b", i + 1, bits[i], got, bus.match_q);
        end
        n_cmp++; if (bus.match_count !== CNT_W'(2)) begin n_bad++; $display("FAIL default_count: got %0d want 2", bus.match_count); end
    endtask

    task automatic test_streams();
        scen_t tbl[3];
        bit got, exp, want, b;
        tbl[0] = '{MAX_LEN'(4'b0101), 3, 1'b0, 16'b10101,   5, 4,  1};
        tbl[1] = '{MAX_LEN'(4'b1101), 4, 1'b1, 16'b1101101, 7, 72, 2};
        tbl[2] = '{MAX_LEN'(4'b1101), 4, 1'b0, 16'b1101101, 7, 8,  1};
        for (int s = 0; s < 3; s++) begin
            load_cfg(tbl[s].pat, tbl[s].len, tbl[s].ovl, got);
            n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL stream%0d_load_match: got %b want 0", s, got); end
            for (int i = 0; i < tbl[s].n; i++) begin
                b    = tbl[s].stream[tbl[s].n - 1 - i];
                want = 1'((tbl[s].mask >> i) & 1);
                drive_bit(1'b1, b, got, exp);
                n_cmp++; if (got !== want) begin n_bad++; $display("FAIL stream%0d_match bit%0d: got %b want %b", s, i + 1, got, want); end
                n_cmp++; if (bus.match_q !== want) begin n_bad++; $display("FAIL stream%0d_match_q bit%0d: got %b want %b", s, i + 1, bus.match_q, want); end
                $display("stream%0d: bit%0d=%b match=%b", s, i + 1, b, got);
            end
            n_cmp++; if (bus.match_count !== CNT_W'(tbl[s].cnt)) begin n_bad++; $display("FAIL stream%0d_count: got %0d want %0d", s, bus.match_count, tbl[s].cnt); end
        end
    endtask

    task automatic test_gaps();
        bit got, exp;
        bit bits[3] = '{1'b1, 1'b0, 1'b1};
        load_cfg(MAX_LEN'(3'b101), 3, 1'b1, got);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b1, bits[i], got, exp);
            n_cmp++; if (got !== (i == 2)) begin n_bad++; $display("FAIL gap_match valid%0d: got %b want %b", i + 1, got, (i == 2)); end
            $display("gaps: valid bit%0d=%b match=%b", i + 1, bits[i], got);
            if (i < 2) begin
                for (int k = 0; k < 3; k++) begin
                    drive_bit(1'b0, 1'($urandom), got, exp);
                    n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL gap_invalid_match: got %b want 0", got); end
                end
            end
        end
        n_cmp++; if (bus.match_count !== CNT_W'(1)) begin n_bad++; $display("FAIL gap_count: got %0d want 1", bus.match_count); end
    endtask

    task automatic test_len0();
        bit got, exp;
        load_cfg(MAX_LEN'($urandom), 0, 1'($urandom), got);
        for (int i = 0; i < 40; i++) begin
            drive_bit(1'($urandom), 1'($urandom), got, exp);
            n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL len0_match cycle%0d: got %b want 0", i, got); end
        end
        n_cmp++; if (bus.match_count !== '0) begin n_bad++; $display("FAIL len0_count: got %0d want 0", bus.match_count); end
        $display("len0: 40 cycles, count=%0d", bus.match_count);
    endtask

    task automatic test_clamp();
        bit got, exp;
        logic [MAX_LEN-1:0] p = MAX_LEN'($urandom);
        load_cfg(p, MAX_LEN + 3, 1'b1, got);
        for (int i = 0; i < 5 + MAX_LEN + 10; i++) begin
            if (i >= 5 && i < 5 + MAX_LEN) drive_bit(1'b1, p[MAX_LEN - 1 - (i - 5)], got, exp);
            else                           drive_bit(1'b1, 1'($urandom), got, exp);
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL clamp_match cycle%0d: got %b want %b", i, got, exp); end
            if (i == 4 + MAX_LEN) begin
                n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL clamp_full_pattern: got %b want 1", got); end
            end
        end
        $display("clamp: pattern=%b count=%0d", p, bus.match_count);
    endtask

    task automatic test_back_to_back();
        bit got, exp;
        load_cfg(MAX_LEN'(2'b11), 2, 1'b1, got);
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b1, 1'b1, got, exp);
            n_cmp++; if (got !== (i >= 1)) begin n_bad++; $display("FAIL b2b_match bit%0d: got %b want %b", i + 1, got, (i >= 1)); end
            $display("b2b: bit%0d match=%b count=%0d", i + 1, got, bus.match_count);
        end
        n_cmp++; if (bus.match_count !== CNT_W'(7)) begin n_bad++; $display("FAIL b2b_count: got %0d want 7", bus.match_count); end
    endtask

    task automatic test_reset_mid();
        bit got, exp;
        load_cfg(MAX_LEN'(3'b101), 3, 1'b1, got);
        drive_bit(1'b1, 1'b1, got, exp);
        drive_bit(1'b1, 1'b0, got, exp);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        #1;
        n_cmp++; if (bus.match !== 1'b1) begin n_bad++; $display("FAIL midreset_armed: got %b want 1", bus.match); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.match !== 1'b0) begin n_bad++; $display("FAIL midreset_match_in_reset: got %b want 0", bus.match); end
        n_cmp++; if (bus.match_count !== '0) begin n_bad++; $display("FAIL midreset_count_in_reset: got %0d want 0", bus.match_count); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_bit(1'b1, 1'b1, got, exp);
        n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL midreset_after_match: got %b want 0", got); end
        n_cmp++; if (bus.match_count !== '0) begin n_bad++; $display("FAIL midreset_count: got %0d want 0", bus.match_count); end
        $display("midreset: match after reset=%b count=%0d", got, bus.match_count);
    endtask

    task automatic test_random();
        bit got, exp, v, b;
        int len, k, errs;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, MAX_LEN);
            load_cfg(MAX_LEN'($urandom), len, 1'($urandom), got);
            n_cmp++; if (got !== 1'b0) begin n_bad++; $display("FAIL rand%0d_load_match: got %b want 0", r, got); end
            k = 0;
            errs = n_bad;
            for (int i = 0; i < 150; i++) begin
                v = ($urandom_range(0, 3) != 0);
                b = ($urandom_range(0, 9) < 7) ? m_pat[len - 1 - (k % len)] : 1'($urandom);
                if (v) k++;
                drive_bit(v, b, got, exp);
                n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rand%0d_match cycle%0d: got %b want %b", r, i, got, exp); end
                n_cmp++; if (bus.match_q !== exp) begin n_bad++; $display("FAIL rand%0d_match_q cycle%0d: got %b want %b", r, i, bus.match_q, exp); end
                n_cmp++; if (bus.match_count !== CNT_W'(m_cnt)) begin n_bad++; $display("FAIL rand%0d_count cycle%0d: got %0d want %0d", r, i, bus.match_count, m_cnt); end
            end
            $display("random%0d: len=%0d pat=%b ovl=%b matches=%0d new_errors=%0d", r, len, m_pat, m_ovl, m_cnt, n_bad - errs);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        bus2.cfg_load    = 1'b1;
        bus2.cfg_pattern = MAX_LEN'(1);
        bus2.cfg_len     = LEN_W'(1);
        bus2.cfg_overlap = 1'b1;
        @(negedge clk);
        bus2.cfg_load = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.in_bit   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (bus2.match !== 1'b1) begin n_bad++; $display("FAIL sat_match bit%0d: got %b want 1", i + 1, bus2.match); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus2.match_count !== want[i]) begin n_bad++; $display("FAIL sat_count bit%0d: got %0d want %0d", i + 1, bus2.match_count, want[i]); end
            $display("saturate: bit%0d count=%0d", i + 1, bus2.match_count);
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.cfg_load     = 1'b0;
        bus.cfg_pattern  = '0;
        bus.cfg_len      = '0;
        bus.cfg_overlap  = 1'b0;
        bus2.in_valid    = 1'b0;
        bus2.in_bit      = 1'b0;
        bus2.cfg_load    = 1'b0;
        bus2.cfg_pattern = '0;
        bus2.cfg_len     = '0;
        bus2.cfg_overlap = 1'b0;

        test_reset();
        test_default();
        test_streams();
        test_gaps();
        test_len0();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector, the generalised successor to the fixed "101" overlapping detector. It watches a qualified serial bit stream and flags, in the same cycle as the final bit, every occurrence of a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping detection is selectable, and matches are counted. It sits in the sequential-logic library between a serial front end and any consumer that needs a same-cycle (Mealy) or registered match strobe.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be ≥2.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len (derived, not overridden).

- clk  input  1  rising-edge clock; sole clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in_bit; no state change when low.
- in_bit  input  1  serial data bit.
- cfg_load  input  1  load configuration and restart the detector.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping.
- match  output  1  Mealy match (combinational from state, in_valid, in_bit).
- match_q  output  1  match registered by one cycle.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- Configuration registers: pat, len, ovl.
  - Reset values: pat = 'b101 (zero-extended), len = 3, ovl = 1. Out of reset the block behaves as the legacy 101 overlapping detector.
- len rules:
  - cfg_len = 0 disables the detector: match is never asserted, but history still shifts.
  - cfg_len > MAX_LEN clamps to MAX_LEN at load.
- State:
  - hist[MAX_LEN-1:0]: shift register of received bits; newest bit in [0].
  - fill[LEN_W-1:0]: number of valid history bits, saturating at MAX_LEN.
  - fill is the FSM state. fill ≥ len-1 is the "armed" condition.
- match = in_valid & !cfg_load & (len≠0) & (fill ≥ len-1) & ({hist[len-2:0], in_bit} == pat[len-1:0]).
  - For len = 1, only in_bit is compared with pat[0].
- Accepted bit (in_valid=1, cfg_load=0), on the clock edge:
  - hist <= {hist[MAX_LEN-2:0], in_bit}.
  - If match & !ovl: fill <= 0. The matched bits cannot start a new match.
  - Otherwise: fill <= min(fill+1, MAX_LEN).
  - If match: match_count <= match_count+1, saturating at 2^CNT_W-1 with no wrap.
- cfg_load = 1 has priority over in_valid:
  - Latch pat, len (clamped) and ovl.
  - Clear fill, hist and match_count to 0.
  - Force match low and discard in_bit that cycle.
- match_q <= match every cycle.
- Async reset: hist = 0, fill = 0, match_count = 0, match_q = 0, config registers to reset values. match is 0 while rst_n is low.

## Timing
- match is valid in the same cycle as the final pattern bit (zero latency). It is combinational, with no path from cfg_* except through cfg_load gating.
- match_q, match_count and fill reflect a match one clock edge later.
- Reset assertion is asynchronous and can occur mid-pattern: partial history is lost, with no spurious match during or after reset. Deassertion is used synchronously by the consuming system.
- in_valid low cycles are invisible: a pattern may be spread across non-contiguous valid cycles.
- Back-to-back matches are possible every cycle, e.g. pattern "1", or "11" in overlap mode on an all-ones stream.
- No illegal states: fill is saturating, and any hist value is legal.

## Test plan
- Default after reset, valid stream 1,0,1,0,1 → match on bits 3 and 5; match_q one cycle after each; match_count = 2.
- cfg_load pat=...101, len=3, ovl=0; stream 1,0,1,0,1 → match on bit 3 only; match_count = 1.
- cfg_load pat=1101, len=4:
  - With ovl=1, stream 1,1,0,1,1,0,1 → matches on bits 4 and 7.
  - Reload with ovl=0, same stream → match on bit 4 only.
- Pattern 101 with in_valid low for 3 cycles between each bit (in_bit toggling randomly while invalid) → single match on the third valid bit; no assertion during invalid cycles.
- CNT_W=2, pattern "1", len=1, 6 valid ones → match every cycle; match_count 1,2,3,3,3,3 (saturates).
- Boundary cases:
  - cfg_len=0 with any stream → match never asserts.
  - cfg_len=MAX_LEN+3 → behaves as len=MAX_LEN.
  - rst_n pulsed low after bits 1,0 of "101", then 1 sent → no match; match_count = 0.
